// File: rtl/audio_sample_sequencer.sv
// Sequences one stereo sample per pass: fetch a ROM word, wait for the codec, transfer.
// Define AUDIO_SEQ_ONESHOT_EN to stop in DONE after the last ROM word instead of looping.
module audio_sample_sequencer #(
  parameter int DATA_W    = 24,
  parameter int ADDR_W    = 16,
  parameter int ROM_DEPTH = 48000,
  parameter int ROM_LAT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              src_rom,
  input  logic              read_ready,
  input  logic              write_ready,
  input  logic [DATA_W-1:0] mic_left,
  input  logic [DATA_W-1:0] mic_right,
  input  logic [DATA_W-1:0] rom_q,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              codec_read,
  output logic              codec_write,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              sample_strobe,
  output logic              wrap,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_RDY, XFER, DONE} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] lat_cnt;
  logic       both_rdy;
  logic       last_addr;

  assign both_rdy  = read_ready & write_ready;
  assign last_addr = (rom_addr == ADDR_W'(ROM_DEPTH - 1));

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    codec_read    = 1'b0;
    codec_write   = 1'b0;
    sample_strobe = 1'b0;
    wrap          = 1'b0;
    busy          = (state != IDLE);
    case (state)
      IDLE:     if (enable) state_nxt = FETCH;
      // Counter runs regardless of the readies, so the ROM always gets its full latency.
      FETCH:    if (lat_cnt == 3'(ROM_LAT - 1)) state_nxt = WAIT_RDY;
      WAIT_RDY: if (both_rdy) state_nxt = XFER;
      XFER: begin
        codec_read    = 1'b1;
        codec_write   = 1'b1;
        sample_strobe = 1'b1;
        wrap          = last_addr;
        state_nxt     = enable ? FETCH : IDLE;
`ifdef AUDIO_SEQ_ONESHOT_EN
        if (last_addr) state_nxt = DONE;
`endif
      end
      DONE:     if (!enable) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  // NOTE: the reset clears only true state; strobes, wrap and busy decode from state and follow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= 3'd0;
      rom_addr  <= '0;
      out_left  <= '0;
      out_right <= '0;
    end else begin
      state   <= state_nxt;
      lat_cnt <= (state == FETCH) ? lat_cnt + 3'd1 : 3'd0;
      // src_rom only matters at the instant the sample is captured.
      if (state == WAIT_RDY && both_rdy) begin
        out_left  <= src_rom ? rom_q : mic_left;
        out_right <= src_rom ? rom_q : mic_right;
      end
      if (state == XFER)
        rom_addr <= last_addr ? '0 : rom_addr + 1'b1;
    end
  end

endmodule

// File: doc/audio_sample_sequencer.md
AUDIO_SAMPLE_SEQUENCER -- requirements
Module: audio_sample_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 24, sample width.
- ADDR_W, 16, ROM address width.
- ROM_DEPTH, 48000, number of valid ROM words.
- ROM_LAT, 2, ROM read latency in cycles, legal range 1-7.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock, all logic on its rising edge.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: run request.
- src_rom, in, 1: 1 = ROM source, 0 = mic source.
- read_ready, in, 1: codec has ADC data.
- write_ready, in, 1: codec accepts DAC data.
- mic_left, in, DATA_W: codec readdata left.
- mic_right, in, DATA_W: codec readdata right.
- rom_q, in, DATA_W: ROM output data.
- rom_addr, out, ADDR_W: ROM address.
- codec_read, out, 1: codec read strobe.
- codec_write, out, 1: codec write strobe.
- out_left, out, DATA_W: codec writedata left.
- out_right, out, DATA_W: codec writedata right.
- sample_strobe, out, 1: filter/accumulator enable.
- wrap, out, 1: last ROM word transferred.
- busy, out, 1: not in IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, FETCH, WAIT_RDY, XFER and DONE.
REQ-004 IDLE SHALL go to FETCH when enable=1 and SHALL otherwise stay in IDLE.
REQ-005 FETCH SHALL hold rom_addr stable for exactly ROM_LAT cycles using an internal latency counter, then go to WAIT_RDY.
REQ-006 WAIT_RDY SHALL go to XFER on the first cycle with read_ready=1 and write_ready=1.
REQ-007 On that WAIT_RDY-to-XFER edge, out_left and out_right SHALL load rom_q (both channels) when src_rom=1, or mic_left and mic_right when src_rom=0.
REQ-008 src_rom SHALL be sampled only on the WAIT_RDY-to-XFER edge.
REQ-009 XFER SHALL last exactly one cycle, with codec_read=1, codec_write=1 and sample_strobe=1 in that cycle only.
REQ-010 codec_read, codec_write and sample_strobe SHALL be 0 in every state other than XFER.
REQ-011 Ready signals seen during FETCH SHALL NOT shorten the ROM_LAT wait.
REQ-012 Leaving XFER, rom_addr SHALL increment by 1 when rom_addr < ROM_DEPTH-1.
REQ-013 Leaving XFER with rom_addr = ROM_DEPTH-1, rom_addr SHALL become 0 and wrap SHALL be 1 during that XFER cycle.
REQ-014 After XFER, the next state SHALL be FETCH if enable=1, otherwise IDLE.
REQ-015 Deasserting enable during FETCH or WAIT_RDY SHALL NOT abort the sample; the current sample completes and the FSM then returns to IDLE.
REQ-016 rom_addr SHALL be retained across IDLE, so playback resumes where it stopped.
REQ-017 out_left and out_right SHALL hold their value outside the load edge.
REQ-018 busy SHALL be 1 in FETCH, WAIT_RDY, XFER and DONE.
REQ-019 Per-sample latency SHALL be ROM_LAT + 1 + W cycles, where W is the number of WAIT_RDY cycles (W >= 1).

Reset
REQ-020 On clk with reset=1, the FSM SHALL enter IDLE, the latency counter SHALL clear and rom_addr, out_left, out_right, codec_read, codec_write, sample_strobe, wrap and busy SHALL all be 0.
REQ-021 reset SHALL take priority over all other inputs in every state, including mid-XFER; no strobe SHALL be emitted in the cycle after reset.

Configuration
REQ-022 With macro AUDIO_SEQ_ONESHOT_EN defined, after the wrap XFER the FSM SHALL enter DONE instead of FETCH or IDLE.
REQ-023 In DONE (AUDIO_SEQ_ONESHOT_EN defined), no strobes SHALL be emitted, rom_addr SHALL stay 0, and the FSM SHALL return to IDLE when enable=0.
REQ-024 With AUDIO_SEQ_ONESHOT_EN undefined, playback SHALL loop continuously, the DONE state SHALL be unreachable, and all other behaviour SHALL be identical.

Verification
REQ-025 Reset, then enable=1 with both readies held at 1 and ROM_LAT=2 -> first codec_read/codec_write/sample_strobe pulse on cycle 4 after enable, then one pulse every 4 cycles; rom_addr steps 0,1,2.
REQ-026 src_rom=1, rom_q=24'h123456 -> at the strobe, out_left=out_right=24'h123456; src_rom=0, mic_left=24'hABCDEF, mic_right=24'h000011 -> out_left=24'hABCDEF, out_right=24'h000011.
REQ-027 write_ready held 0 for 10 cycles in WAIT_RDY -> no strobes, rom_addr and outputs unchanged; the strobe appears exactly 1 cycle after write_ready rises.
REQ-028 ROM_DEPTH=4, continuous readies -> rom_addr sequence 0,1,2,3,0 with wrap=1 only in the addr-3 XFER cycle; with AUDIO_SEQ_ONESHOT_EN defined, the FSM reaches DONE and stays there until enable=0.
REQ-029 reset=1 asserted during the XFER cycle -> next cycle all outputs 0 and the FSM in IDLE; enable dropped in FETCH -> exactly one more strobe, then IDLE.
